// File: rtl/prbs15_checker_if.sv
// Stream/status bundle between a PRBS-15 bit source and prbs15_checker.
// BitCount is present only when PRBS15_CHK_BITCNT_EN is defined.
interface prbs15_checker_if #(
  parameter int CNT_W = 16
);
  logic             InBit;
  logic             InValid;
  logic             ClrCount;
  logic             Locked;
  logic             ErrPulse;
  logic             SyncLost;
  logic [CNT_W-1:0] ErrCount;
`ifdef PRBS15_CHK_BITCNT_EN
  logic [31:0]      BitCount;

  modport master (
    output InBit, InValid, ClrCount,
    input  Locked, ErrPulse, SyncLost, ErrCount, BitCount
  );
  modport slave (
    input  InBit, InValid, ClrCount,
    output Locked, ErrPulse, SyncLost, ErrCount, BitCount
  );
`else
  modport master (
    output InBit, InValid, ClrCount,
    input  Locked, ErrPulse, SyncLost, ErrCount
  );
  modport slave (
    input  InBit, InValid, ClrCount,
    output Locked, ErrPulse, SyncLost, ErrCount
  );
`endif
endinterface

// File: rtl/prbs15_checker.sv
// PRBS-15 (x^15+x^14+1) self-synchronising checker with lock, windowed loss-of-sync and error count.
// Optional locked-bit counter (BitCount) when PRBS15_CHK_BITCNT_EN is defined.
module prbs15_checker #(
  parameter int LOCK_CNT = 16,
  parameter int ERR_WIN  = 64,
  parameter int ERR_THR  = 8,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  prbs15_checker_if.slave   bus
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(ERR_WIN);
  localparam int EW = $clog2(ERR_THR + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(ERR_WIN - 1);
  localparam logic [EW-1:0] THR_V     = EW'(ERR_THR);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [14:0]      r_q, r_d;
  logic [3:0]       ld_cnt_q, ld_cnt_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WW-1:0]    win_cnt_q, win_cnt_d;
  logic [EW-1:0]    win_err_q, win_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             sync_lost_q, sync_lost_d;
`ifdef PRBS15_CHK_BITCNT_EN
  logic [31:0]      bit_cnt_q, bit_cnt_d;
`endif

  logic          pred;
  logic [14:0]   r_shift;
  logic          err_hit;
  logic          checked;
  logic [EW-1:0] win_err_inc;

  assign pred    = r_q[13] ^ r_q[14];
  assign r_shift = {r_q[13:0], bus.InBit};

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    ld_cnt_d    = ld_cnt_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    sync_lost_d = 1'b0;
    err_hit     = 1'b0;
    checked     = 1'b0;
    win_err_inc = win_err_q;
    if (bus.InValid) begin
      unique case (state_q)
        SEED: begin
          r_d = r_shift;
          if (ld_cnt_q == 4'd14) begin
            ld_cnt_d = '0;
            if (r_shift != '0) begin
              state_d = VERIFY;
              match_d = '0;
            end
          end else begin
            ld_cnt_d = ld_cnt_q + 4'd1;
          end
        end
        VERIFY: begin
          r_d = r_shift;
          if (bus.InBit == pred) begin
            if (match_q == LOCK_LAST) begin
              state_d   = LOCKED;
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
          // An all-zero register would free-run at zero once locked, so it always reseeds.
          if (r_shift == '0) begin
            state_d  = SEED;
            ld_cnt_d = '0;
          end
        end
        LOCKED: begin
          r_d         = {r_q[13:0], pred};
          checked     = 1'b1;
          err_hit     = (bus.InBit != pred);
          err_pulse_d = err_hit;
          win_err_inc = win_err_q + EW'(err_hit);
          if (win_err_inc == THR_V) begin
            sync_lost_d = 1'b1;
            state_d     = SEED;
            ld_cnt_d    = '0;
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_inc;
          end
        end
        default: begin
          state_d  = SEED;
          ld_cnt_d = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);

    err_cnt_d = err_cnt_q;
    if (bus.ClrCount) begin
      err_cnt_d = CNT_W'(err_hit);
    end else if (err_hit && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end

`ifdef PRBS15_CHK_BITCNT_EN
    bit_cnt_d = bit_cnt_q;
    if (bus.ClrCount) begin
      bit_cnt_d = 32'(checked);
    end else if (checked && (bit_cnt_q != '1)) begin
      bit_cnt_d = bit_cnt_q + 32'd1;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= SEED;
      r_q         <= '0;
      ld_cnt_q    <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      sync_lost_q <= 1'b0;
`ifdef PRBS15_CHK_BITCNT_EN
      bit_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      ld_cnt_q    <= ld_cnt_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      sync_lost_q <= sync_lost_d;
`ifdef PRBS15_CHK_BITCNT_EN
      bit_cnt_q   <= bit_cnt_d;
`endif
    end
  end

  assign bus.Locked   = locked_q;
  assign bus.ErrPulse = err_pulse_q;
  assign bus.SyncLost = sync_lost_q;
  assign bus.ErrCount = err_cnt_q;
`ifdef PRBS15_CHK_BITCNT_EN
  assign bus.BitCount = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs15_checker.sv
// Directed bench for prbs15_checker: default-parameter instance plus a CNT_W=4, ERR_THR=ERR_WIN instance.
module tb_prbs15_checker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  prbs15_checker_if #(.CNT_W(16)) if1 ();
  prbs15_checker_if #(.CNT_W(4))  if2 ();

  assign if1.InBit    = in_bit;
  assign if1.InValid  = in_valid;
  assign if1.ClrCount = clr;
  assign if2.InBit    = in_bit;
  assign if2.InValid  = in_valid;
  assign if2.ClrCount = clr;

  prbs15_checker #(.LOCK_CNT(16), .ERR_WIN(64), .ERR_THR(8), .CNT_W(16)) u_dut1 (
    .CLK(clk), .RST(rst), .bus(if1.slave)
  );
  prbs15_checker #(.LOCK_CNT(16), .ERR_WIN(64), .ERR_THR(64), .CNT_W(4)) u_dut2 (
    .CLK(clk), .RST(rst), .bus(if2.slave)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned pulses = 0;
  int unsigned sls = 0;
  logic [14:0] gen;

  typedef struct {
    bit          rst;
    int unsigned src;        // 0 generator, 1 all-zero, 2 all-one
    int unsigned bits;
    int unsigned ninv;       // inverted bits at offsets 0,2,4,...
    bit          clr;        // ClrCount on the first bit
    bit          exp_locked;
    int unsigned exp_pulses;
    int unsigned exp_sl;
    int unsigned exp_cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic gen_next(output logic b);
    b   = gen[14];
    gen = {gen[13:0], gen[13] ^ gen[14]};
  endtask

  task automatic step(input logic b, input logic v, input logic c);
    in_bit   = b;
    in_valid = v;
    clr      = c;
    @(posedge clk);
    #1;
    pulses += int'(if1.ErrPulse);
    sls    += int'(if1.SyncLost);
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    gen = 15'h2ABC;
  endtask

  initial begin
    logic b;
    int unsigned vcount, lock_at, cyc;

    //             rst src bits ninv clr  L  pulses sl cnt
    vecs[0]  = '{1'b1, 0,  30, 0, 1'b0, 1'b0, 0, 0, 0};
    vecs[1]  = '{1'b0, 0,   1, 0, 1'b0, 1'b1, 0, 0, 0};
    vecs[2]  = '{1'b0, 0, 469, 0, 1'b0, 1'b1, 0, 0, 0};
    vecs[3]  = '{1'b0, 0,  43, 0, 1'b0, 1'b1, 0, 0, 0};
    vecs[4]  = '{1'b0, 0,  64, 1, 1'b0, 1'b1, 1, 0, 1};
    vecs[5]  = '{1'b0, 0,  64, 7, 1'b0, 1'b1, 7, 0, 8};
    vecs[6]  = '{1'b0, 0,  64, 7, 1'b0, 1'b1, 7, 0, 15};
    vecs[7]  = '{1'b0, 0,  16, 8, 1'b0, 1'b0, 8, 1, 23};
    vecs[8]  = '{1'b0, 0,  29, 0, 1'b0, 1'b0, 0, 0, 23};
    vecs[9]  = '{1'b0, 0,   1, 0, 1'b0, 1'b1, 0, 0, 23};
    vecs[10] = '{1'b0, 0,   1, 1, 1'b1, 1'b1, 1, 0, 1};
    vecs[11] = '{1'b0, 0,   1, 0, 1'b1, 1'b1, 0, 0, 0};
    vecs[12] = '{1'b1, 1, 200, 0, 1'b0, 1'b0, 0, 0, 0};
    vecs[13] = '{1'b1, 2, 200, 0, 1'b0, 1'b0, 0, 0, 0};

    do_reset();
    check("reset Locked",   if1.Locked,   0);
    check("reset ErrPulse", if1.ErrPulse, 0);
    check("reset SyncLost", if1.SyncLost, 0);
    check("reset ErrCount", if1.ErrCount, 0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) do_reset();
      pulses = 0;
      sls    = 0;
      for (int unsigned k = 0; k < vecs[i].bits; k++) begin
        gen_next(b);
        if (vecs[i].src == 1) b = 1'b0;
        if (vecs[i].src == 2) b = 1'b1;
        if ((k < 2 * vecs[i].ninv) && (k % 2 == 0)) b = ~b;
        step(b, 1'b1, vecs[i].clr && (k == 0));
      end
      check($sformatf("vec%0d Locked", i),   if1.Locked,   vecs[i].exp_locked);
      check($sformatf("vec%0d pulses", i),   pulses,       vecs[i].exp_pulses);
      check($sformatf("vec%0d synclost", i), sls,          vecs[i].exp_sl);
      check($sformatf("vec%0d ErrCount", i), if1.ErrCount, vecs[i].exp_cnt);
`ifdef PRBS15_CHK_BITCNT_EN
      if (i == 2) check("BitCount after 469 locked bits", if1.BitCount, 469);
`endif
    end

    // Clean stream with random InValid gaps: lock must follow exactly the 31st valid bit.
    do_reset();
    pulses = 0;
    vcount = 0;
    lock_at = 0;
    cyc = 0;
    while (vcount < 40 && cyc < 2000) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      if (v) gen_next(b);
      else b = 1'($urandom_range(0, 1));
      step(b, v, 1'b0);
      if (v) vcount++;
      if (if1.Locked && lock_at == 0) lock_at = vcount;
      cyc++;
    end
    check("gaps cycle budget", int'(cyc < 2000), 1);
    check("gaps lock point", lock_at, 31);
    check("gaps no ErrPulse", pulses, 0);

    // Narrow counter saturation and clear-with-error on the second instance.
    do_reset();
    for (int k = 0; k < 31; k++) begin
      gen_next(b);
      step(b, 1'b1, 1'b0);
    end
    check("dut2 locked", if2.Locked, 1);
    for (int e = 0; e < 20; e++) begin
      for (int k = 0; k < 4; k++) begin
        gen_next(b);
        step((k == 0) ? ~b : b, 1'b1, 1'b0);
      end
    end
    check("dut2 ErrCount saturated", if2.ErrCount, 15);
    check("dut2 still locked", if2.Locked, 1);
    gen_next(b);
    step(~b, 1'b1, 1'b1);
    check("dut2 clear with error", if2.ErrCount, 1);
    check("dut2 clear-edge pulse", if2.ErrPulse, 1);

    // Reset while locked, on an erroneous valid bit.
    gen_next(b);
    rst = 1'b1;
    step(~b, 1'b1, 1'b0);
    rst = 1'b0;
    check("rst mid-lock Locked",   if2.Locked,   0);
    check("rst mid-lock ErrPulse", if2.ErrPulse, 0);
    check("rst mid-lock SyncLost", if2.SyncLost, 0);
    check("rst mid-lock ErrCount", if2.ErrCount, 0);
    check("rst mid-lock dut1 ErrCount", if1.ErrCount, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
